instr_fetch_unit: RTL

//   Reader side of the PC register: samples the current PC, fetches the instruction from

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_timeout_ctr.sv | 37 +++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional timeout support is selected with the IFU_TIMEOUT_EN macro (see instr_fetch_unit).
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ifu_state_e;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Cycle counter bounding how long a fetch may wait for memory.
// Only instantiated when IFU_TIMEOUT_EN is defined.
module ifu_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The cycle entering REQ counts as zero, so expiry lands on the TIMEOUT-th request cycle.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one instruction per request: latches PC, handshakes with memory, pulses IR/PC updates.
// Define IFU_TIMEOUT_EN to abort stalled fetches after TIMEOUT cycles and raise fetch_err.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_wre,
  output logic              fetch_busy,
  output logic              fetch_err
);

  ifu_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_wre_q, pc_wre_d;
  logic              fetch_err_q, fetch_err_d;
  logic              tmo_expired;
  logic              pc_lo_unused;

  // Fetch addresses are word aligned; the low PC bits never reach memory.
  assign pc_lo_unused = ^pc_in[1:0];

`ifdef IFU_TIMEOUT_EN
  ifu_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (CLK),
    .rst    (RST),
    .clear  ((state_q == IDLE) && fetch_start),
    .enable ((state_q == REQ) || (state_q == WAIT)),
    .expired(tmo_expired)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign tmo_expired    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    next_pc_d   = next_pc_q;
    ir_valid_d  = 1'b0;
    pc_wre_d    = 1'b0;
    fetch_err_d = fetch_err_q;
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          mem_addr_d  = {pc_in[ADDR_W-1:2], 2'b00};
          mem_req_d   = 1'b1;
          fetch_err_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ, WAIT: begin
        // Flush beats a same-cycle ack; ack beats a same-cycle timeout.
        if (flush) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (mem_ack) begin
          ir_d       = mem_rdata;
          next_pc_d  = mem_addr_q + ADDR_W'(PC_STEP);
          mem_req_d  = 1'b0;
          ir_valid_d = 1'b1;
          pc_wre_d   = 1'b1;
          state_d    = DONE;
        end else if (tmo_expired) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ir_q        <= DATA_W'(NOP_INSTR);
      next_pc_q   <= '0;
      ir_valid_q  <= 1'b0;
      pc_wre_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      next_pc_q   <= next_pc_d;
      ir_valid_q  <= ir_valid_d;
      pc_wre_q    <= pc_wre_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign ir_out     = ir_q;
  assign next_pc    = next_pc_q;
  assign ir_valid   = ir_valid_q;
  assign pc_wre     = pc_wre_q;
  assign fetch_busy = (state_q != IDLE);
  assign fetch_err  = fetch_err_q;

endmodule
